// File: rtl/vector_ram_pkg.sv
// vector_ram_pkg: shared FSM state type and default sizes for the vector RAM slave
// Ports: none (package)
package vector_ram_pkg;
    localparam int DEF_ADDR_WIDTH  = 5;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_PARALLELISM = 3;
    typedef enum logic [1:0] {IDLE, RRESP, BRESP} state_t;
endpackage

// File: rtl/vector_ram_if.sv
// vector_ram_if: vector RAM bus, PARALLELISM lanes of address/data plus request and R/B response handshakes
// Ports: none; master drives addr/wdata/write/valid/bready/rready, slave drives ready/bdata/bvalid/rdata/rvalid
interface vector_ram_if import vector_ram_pkg::*; #(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PARALLELISM = DEF_PARALLELISM
);
    logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata;
    logic                                   write;
    logic                                   valid;
    logic                                   ready;
    logic [DATA_WIDTH-1:0]                  bdata;
    logic                                   bvalid;
    logic                                   bready;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata;
    logic                                   rvalid;
    logic                                   rready;
    modport master (
        output addr, wdata, write, valid, bready, rready,
        input  ready, bdata, bvalid, rdata, rvalid
    );
    modport slave (
        input  addr, wdata, write, valid, bready, rready,
        output ready, bdata, bvalid, rdata, rvalid
    );
endinterface

// File: rtl/vector_ram_array.sv
// vector_ram_array: DEPTH x DATA_WIDTH flop array with per-lane combinational reads and lane-priority writes
// Ports: clk, rst_n (async clear), i_we, i_addr[P], i_wdata[P] in; o_rdata[P] out
module vector_ram_array import vector_ram_pkg::*; #(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PARALLELISM = DEF_PARALLELISM
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_we,
    input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] i_addr,
    input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] i_wdata,
    output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] o_rdata
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    // later lanes overwrite earlier ones, so the highest lane wins on collisions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (i_we) begin
            for (int k = 0; k < PARALLELISM; k++) r_mem[i_addr[k]] <= i_wdata[k];
        end
    end
    always_comb begin
        for (int k = 0; k < PARALLELISM; k++) o_rdata[k] = r_mem[i_addr[k]];
    end
endmodule

// File: rtl/vector_ram_slave.sv
// vector_ram_slave: responder for the vector RAM bus, one R or B beat per accepted request
// Ports: clk, rst_n (async active-low), bus (vector_ram_if.slave)
module vector_ram_slave import vector_ram_pkg::*; #(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PARALLELISM = DEF_PARALLELISM
) (
    input logic         clk,
    input logic         rst_n,
    vector_ram_if.slave bus
);
    state_t                                 r_state, w_next;
    logic                                   w_ready, w_accept;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] w_rd, r_rdata;
    logic [DATA_WIDTH-1:0]                  r_cnt;
    vector_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PARALLELISM(PARALLELISM)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_accept && bus.write),
        .i_addr (bus.addr),
        .i_wdata(bus.wdata),
        .o_rdata(w_rd)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // ready means "the slot is free this cycle": idle, or the pending response is being taken
    always_comb begin
        w_ready  = (r_state == IDLE) || (r_state == RRESP && bus.rready) || (r_state == BRESP && bus.bready);
        w_accept = bus.valid && w_ready;
        w_next   = w_accept ? (bus.write ? BRESP : RRESP) : (w_ready ? IDLE : r_state);
    end
    // the write counter doubles as bdata: it only moves on an accepted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            if (bus.write) r_cnt <= r_cnt + DATA_WIDTH'(1);
            else           r_rdata <= w_rd;
        end
    end
    assign bus.ready  = w_ready;
    assign bus.rvalid = (r_state == RRESP);
    assign bus.bvalid = (r_state == BRESP);
    assign bus.rdata  = r_rdata;
    assign bus.bdata  = r_cnt;
endmodule

// File: tb/tb_vector_ram_slave.sv
// tb_vector_ram_slave: directed stimulus with a behavioural memory/response model checked every cycle
module tb_vector_ram_slave;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int P  = 3;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    vector_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLELISM(P)) bus ();
    vector_ram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PARALLELISM(P)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask
    // model: memory contents, write count, and the one outstanding response (0 none, 1 read, 2 write)
    logic [DW-1:0] m_mem [32];
    logic [DW-1:0] m_cnt;
    logic [DW-1:0] m_rd [P];
    logic [DW-1:0] m_bd;
    int            m_kind;
    function automatic bit m_free();
        return m_kind == 0 || (m_kind == 1 && bus.rready) || (m_kind == 2 && bus.bready);
    endfunction
    always @(posedge clk or negedge rst_n) begin
        bit acc;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
            for (int i = 0; i < P; i++) m_rd[i] = '0;
            m_cnt  = '0;
            m_bd   = '0;
            m_kind = 0;
        end else begin
            acc = bus.valid && m_free();
            if (m_free()) m_kind = 0;
            if (acc && bus.write) begin
                for (int i = 0; i < P; i++) m_mem[bus.addr[i]] = bus.wdata[i];
                m_cnt  = m_cnt + 1;
                m_bd   = m_cnt;
                m_kind = 2;
            end else if (acc) begin
                for (int i = 0; i < P; i++) m_rd[i] = m_mem[bus.addr[i]];
                m_kind = 1;
            end
        end
    end
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("ready", bus.ready, m_free());
            chk("rvalid", bus.rvalid, m_kind == 1);
            chk("bvalid", bus.bvalid, m_kind == 2);
            if (m_kind == 1) for (int i = 0; i < P; i++) chk("rdata", bus.rdata[i], m_rd[i]);
            if (m_kind == 2) chk("bdata", bus.bdata, m_bd);
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic req(input logic w, input logic [AW-1:0] a0, a1, a2, input logic [DW-1:0] d0, d1, d2);
        int n = 0;
        bus.write = w;
        bus.addr  = {a2, a1, a0};
        bus.wdata = {d2, d1, d0};
        bus.valid = 1'b1;
        @(negedge clk);
        while (!bus.ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ready) chk("accept_timeout", 32'd0, 32'd1);
        step();
        bus.valid = 1'b0;
    endtask
    task automatic exp_r(input logic [DW-1:0] e0, e1, e2);
        @(negedge clk);
        chk("lit_rvalid", bus.rvalid, 1'b1);
        chk("lit_rdata0", bus.rdata[0], e0);
        chk("lit_rdata1", bus.rdata[1], e1);
        chk("lit_rdata2", bus.rdata[2], e2);
        step();
    endtask
    task automatic exp_b(input logic [DW-1:0] e);
        @(negedge clk);
        chk("lit_bvalid", bus.bvalid, 1'b1);
        chk("lit_bdata", bus.bdata, e);
        step();
    endtask
    initial begin
        int kk;
        bus.valid  = 1'b0;
        bus.write  = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_bdata", bus.bdata, 32'd0);
        for (int i = 0; i < P; i++) chk("rst_rdata", bus.rdata[i], 32'd0);
        cmp_en = 1'b1;
        step();
        req(1'b0, 5'd0, 5'd5, 5'd31, 0, 0, 0);
        exp_r(0, 0, 0);
        req(1'b1, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
        exp_b(1);
        req(1'b0, 5'd3, 5'd1, 5'd2, 0, 0, 0);
        exp_r(32'hC, 32'hA, 32'hB);
        bus.rready = 1'b0;
        req(1'b0, 5'd1, 5'd2, 5'd3, 0, 0, 0);
        repeat (4) begin
            @(negedge clk);
            chk("bp_rvalid", bus.rvalid, 1'b1);
            chk("bp_ready", bus.ready, 1'b0);
            chk("bp_rdata0", bus.rdata[0], 32'hA);
            chk("bp_rdata2", bus.rdata[2], 32'hC);
        end
        step();
        bus.rready = 1'b1;
        bus.write  = 1'b1;
        bus.addr   = {5'd7, 5'd7, 5'd7};
        bus.wdata  = {32'd3, 32'd2, 32'd1};
        bus.valid  = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", bus.ready, 1'b1);
        step();
        bus.valid = 1'b0;
        exp_b(2);
        req(1'b0, 5'd7, 5'd7, 5'd7, 0, 0, 0);
        exp_r(3, 3, 3);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            kk = k / 2;
            bus.write = (k % 2 == 0);
            bus.addr  = {5'(10 + 3 * kk), 5'(9 + 3 * kk), 5'(8 + 3 * kk)};
            bus.wdata = {32'((kk + 1) * 16 + 2), 32'((kk + 1) * 16 + 1), 32'((kk + 1) * 16)};
            bus.valid = 1'b1;
            @(negedge clk);
            chk("stream_ready", bus.ready, 1'b1);
            if (k > 0 && (k - 1) % 2 == 0) chk("stream_bdata", bus.bvalid ? bus.bdata : 32'hFFFF_FFFF, 32'((k - 1) / 2 + 1));
            if (k > 0 && (k - 1) % 2 == 1) chk("stream_rdata", bus.rvalid ? bus.rdata[1] : 32'hFFFF_FFFF, 32'(((k - 1) / 2 + 1) * 16 + 1));
            step();
        end
        bus.valid = 1'b0;
        exp_r(64, 65, 66);
        bus.bready = 1'b0;
        req(1'b1, 5'd20, 5'd21, 5'd22, 32'd5, 32'd6, 32'd7);
        @(negedge clk);
        chk("mid_bvalid", bus.bvalid, 1'b1);
        chk("mid_bdata", bus.bdata, 32'd5);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bvalid", bus.bvalid, 1'b0);
        chk("mid_rst_rvalid", bus.rvalid, 1'b0);
        chk("mid_rst_bdata", bus.bdata, 32'd0);
        step();
        rst_n = 1'b1;
        bus.bready = 1'b1;
        step();
        req(1'b0, 5'd20, 5'd21, 5'd22, 0, 0, 0);
        exp_r(0, 0, 0);
        req(1'b0, 5'd8, 5'd9, 5'd10, 0, 0, 0);
        exp_r(0, 0, 0);
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
